// File: rtl/fb_avl_port_if.sv
`default_nettype none
// ============================================================================
// Module      : fb_avl_port_if
// Description : Bundles the controller-side request signals and the
//               Avalon-MM memory-side signals of one frame-buffer port.
//               The slave view belongs to the port; the master view
//               belongs to the controller/memory environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface fb_avl_port_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 26
);
  // controller side
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic                  avl_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_valid;
  logic                  full;
  logic                  rd_done;
  logic                  protocol_err;
  // memory side
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_write_req;
  logic                  mem_read_req;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rdata_valid;

  modport master (
    output wr_en, wr_data, rd_en, mem_ready, mem_rdata, mem_rdata_valid,
    input  avl_ready, rd_data, rd_data_valid, full, rd_done, protocol_err,
    input  mem_address, mem_write_req, mem_read_req, mem_wdata
  );

  modport slave (
    input  wr_en, wr_data, rd_en, mem_ready, mem_rdata, mem_rdata_valid,
    output avl_ready, rd_data, rd_data_valid, full, rd_done, protocol_err,
    output mem_address, mem_write_req, mem_read_req, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/fb_avl_port.sv
`default_nettype none
// ============================================================================
// Module      : fb_avl_port
// Description : Frame-buffer memory port. Turns active-low write/read
//               requests into single-word Avalon-MM transfers at
//               auto-incrementing frame addresses, returns read data with
//               a valid strobe and flags end-of-frame on both directions.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_avl_port #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 26,
  parameter int BASE_ADDR       = 0,
  parameter int FRAME_WORDS     = 307200,
  parameter int MAX_OUTSTANDING = 8
) (
  input  wire logic     clk,
  input  wire logic     reset,
  fb_avl_port_if.slave  bus
);

  // Frame counters hold 0..FRAME_WORDS-1; the issue counter must also be
  // able to represent FRAME_WORDS itself.
  localparam int CW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int IW = $clog2(FRAME_WORDS + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CW-1:0]         c_last_word  = CW'(FRAME_WORDS - 1);
  localparam logic [IW-1:0]         c_last_issue = IW'(FRAME_WORDS - 1);
  localparam logic [OW-1:0]         c_max_out    = OW'(MAX_OUTSTANDING);
  localparam logic [OW-1:0]         c_one_out    = OW'(1);
  localparam logic [ADDR_WIDTH-1:0] c_base       = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_wr_addr;
  logic [CW-1:0]         r_rd_addr;
  logic [IW-1:0]         r_issued;
  logic [OW-1:0]         r_outstanding;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_data_valid;
  logic                  r_full;
  logic                  r_rd_done;
  logic                  r_protocol_err;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_ret_ok;
  logic                  w_ret_bad;
  logic                  w_last_ret;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  // Request decode, read-return classification and next state; requests are
  // gated by reset so nothing is issued while the port is held in reset.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_acc    = reset && !bus.wr_en && bus.mem_ready;
    w_rd_acc    = reset && !bus.rd_en && bus.wr_en && bus.mem_ready &&
                  (r_state == S_RUN) && (r_outstanding < c_max_out);
    w_ret_ok    = bus.mem_rdata_valid && (r_outstanding != '0);
    w_ret_bad   = bus.mem_rdata_valid && (r_outstanding == '0);
    w_last_ret  = (r_state == S_DRAIN) && w_ret_ok && (r_outstanding == c_one_out);
    case (r_state)
      S_RUN:   if (w_rd_acc && (r_issued == c_last_issue)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_last_ret) w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Write address counter and end-of-frame pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_addr <= '0;
      r_full    <= 1'b0;
    end else begin
      r_full <= w_wr_acc && (r_wr_addr == c_last_word);
      if (w_wr_acc) r_wr_addr <= (r_wr_addr == c_last_word) ? '0 : r_wr_addr + CW'(1);
    end
  end

  // Read address and issue counters; the issue count clears when the frame drains
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_addr <= '0;
      r_issued  <= '0;
    end else begin
      if (w_rd_acc) r_rd_addr <= (r_issued == c_last_issue) ? '0 : r_rd_addr + CW'(1);
      if (w_last_ret)    r_issued <= '0;
      else if (w_rd_acc) r_issued <= r_issued + IW'(1);
    end
  end

  // Outstanding-read counter; a return and an issue in one cycle cancel out
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_outstanding <= '0;
    end else begin
      case ({w_rd_acc, w_ret_ok})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01:   r_outstanding <= r_outstanding - OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Registered read return, frame-read completion and sticky protocol error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_data       <= '0;
      r_rd_data_valid <= 1'b0;
      r_rd_done       <= 1'b0;
      r_protocol_err  <= 1'b0;
    end else begin
      r_rd_data_valid <= w_ret_ok;
      r_rd_done       <= w_last_ret;
      if (w_ret_ok)  r_rd_data      <= bus.mem_rdata;
      if (w_ret_bad) r_protocol_err <= 1'b1;
    end
  end

  // Output drive; the address shows the write pointer only while a write is
  // accepted, otherwise it rests on the read pointer.
  assign bus.avl_ready     = bus.mem_ready;
  assign bus.mem_write_req = w_wr_acc;
  assign bus.mem_read_req  = w_rd_acc;
  assign bus.mem_wdata     = bus.wr_data;
  assign bus.mem_address   = c_base + (w_wr_acc ? ADDR_WIDTH'(r_wr_addr)
                                                : ADDR_WIDTH'(r_rd_addr));
  assign bus.rd_data       = r_rd_data;
  assign bus.rd_data_valid = r_rd_data_valid;
  assign bus.full          = r_full;
  assign bus.rd_done       = r_rd_done;
  assign bus.protocol_err  = r_protocol_err;

endmodule
`default_nettype wire

// File: tb/tb_fb_avl_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_avl_port
// Description : Self-checking bench for fb_avl_port with a latency-modelled
//               memory and a behavioural model of the port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_avl_port;
  localparam int DW = 32, AW = 26, BASE = 100, FW = 16, MAXO = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fb_avl_port_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  fb_avl_port #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE),
    .FRAME_WORDS(FW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {int due; logic [DW-1:0] data;} ret_t;
  ret_t           rq[$];
  logic [DW-1:0]  mem       [FW];
  logic [DW-1:0]  frame_ref [FW];

  int checks = 0, errors = 0, cyc = 0, lat = 5;
  bit spur = 0;
  // behavioural model
  int m_wr, m_rd, m_issued, m_out;
  bit m_drain, m_perr;
  logic [DW-1:0] m_rdata;
  // observations
  int n_wr = 0, n_rd = 0, n_full = 0, n_done = 0, out_obs = 0, out_max = 0;
  logic [AW-1:0] last_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_issued = 0; m_out = 0;
    m_drain = 0; m_perr = 0; m_rdata = '0; out_obs = 0;
  endtask

  // One clock cycle: present memory return, check requests, advance model,
  // cross the edge and check the registered outputs.
  task automatic tick();
    bit ret, wacc, racc, e_valid, e_done, e_full;
    logic [DW-1:0] rv, word;
    int idx;
    ret = 0; rv = '0;
    if (spur) begin
      ret = 1; rv = DW'($urandom);
    end else if (rq.size() > 0 && rq[0].due <= cyc) begin
      ret = 1; rv = rq[0].data; void'(rq.pop_front());
    end
    bus.mem_rdata_valid = ret;
    bus.mem_rdata       = rv;
    #1;
    wacc = (bus.wr_en == 1'b0) && (bus.mem_ready == 1'b1);
    racc = (bus.rd_en == 1'b0) && (bus.wr_en == 1'b1) && (bus.mem_ready == 1'b1) &&
           !m_drain && (m_out < MAXO);
    chk("mem_write_req", bus.mem_write_req, wacc);
    chk("mem_read_req", bus.mem_read_req, racc);
    chk("mem_address", bus.mem_address, AW'(BASE + (wacc ? m_wr : m_rd)));
    chk("avl_ready", bus.avl_ready, bus.mem_ready);
    if (wacc) chk("mem_wdata", bus.mem_wdata, bus.wr_data);
    // memory acts on what the port actually requested
    last_addr = bus.mem_address;
    idx = int'(bus.mem_address) - BASE;
    if (ret && out_obs > 0) out_obs--;
    if (bus.mem_write_req && bus.mem_ready) begin
      n_wr++;
      if (idx >= 0 && idx < FW) mem[idx] = bus.mem_wdata;
    end
    if (bus.mem_read_req && bus.mem_ready) begin
      n_rd++; out_obs++;
      word = (idx >= 0 && idx < FW) ? mem[idx] : '0;
      rq.push_back('{cyc + lat, word});
    end
    if (out_obs > out_max) out_max = out_obs;
    // model update
    e_full  = wacc && (m_wr == FW - 1);
    if (wacc) m_wr = (m_wr + 1) % FW;
    e_valid = ret && (m_out > 0);
    e_done  = e_valid && m_drain && (m_out == 1);
    if (ret && m_out == 0) m_perr = 1;
    if (e_valid) m_rdata = rv;
    m_out = m_out + (racc ? 1 : 0) - (e_valid ? 1 : 0);
    if (racc) begin
      m_issued++;
      m_rd = m_issued % FW;
      if (m_issued == FW) m_drain = 1;
    end
    if (e_done) begin m_drain = 0; m_issued = 0; end
    @(posedge clk); #1; cyc++;
    chk("rd_data_valid", bus.rd_data_valid, e_valid);
    chk("rd_data", bus.rd_data, m_rdata);
    chk("full", bus.full, e_full);
    chk("rd_done", bus.rd_done, e_done);
    chk("protocol_err", bus.protocol_err, m_perr);
    if (bus.full) n_full++;
    if (bus.rd_done) n_done++;
  endtask

  // Read one whole frame with the given memory latency, checking order.
  task automatic read_frame(input int latency);
    int k, guard, done0;
    lat = latency; k = 0; guard = 0; done0 = n_done;
    for (int i = 0; i < FW; i++) frame_ref[i] = mem[i];
    bus.wr_en = 1'b1; bus.rd_en = 1'b0; bus.mem_ready = 1'b1;
    while (n_done == done0 && guard < 400) begin
      tick(); guard++;
      if (bus.rd_data_valid) begin
        if (k < FW) chk("frame_data_order", bus.rd_data, frame_ref[k]);
        k++;
      end
      if (bus.rd_done) chk("rd_done_on_last_valid", k, FW);
    end
    bus.rd_en = 1'b1;
    chk("read_frame_timeout", guard < 400, 1'b1);
    chk("read_frame_valids", k, FW);
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    int wr0, rd0, guard;
    for (int i = 0; i < FW; i++) mem[i] = '0;
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = '0;
    bus.mem_ready = 1'b1; bus.mem_rdata = '0; bus.mem_rdata_valid = 1'b0;
    model_reset();
    #12;
    // reset state
    chk("rst_rd_data_valid", bus.rd_data_valid, 1'b0);
    chk("rst_rd_data", bus.rd_data, '0);
    chk("rst_full", bus.full, 1'b0);
    chk("rst_rd_done", bus.rd_done, 1'b0);
    chk("rst_protocol_err", bus.protocol_err, 1'b0);
    chk("rst_mem_write_req", bus.mem_write_req, 1'b0);
    chk("rst_mem_read_req", bus.mem_read_req, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;

    // write one frame back to back
    for (int i = 0; i < FW; i++) begin
      bus.wr_en = 1'b0; bus.wr_data = DW'($urandom);
      tick();
    end
    bus.wr_en = 1'b1;
    tick();
    chk("wf_accepts", n_wr, FW);
    chk("wf_full_pulses", n_full, 1);

    // second frame under backpressure
    wr0 = n_wr; guard = 0;
    while (n_wr - wr0 < FW && guard < 200) begin
      bus.wr_en = 1'b0; bus.wr_data = DW'($urandom);
      bus.mem_ready = (guard < 8) ? ((guard % 2) == 0) : 1'($urandom_range(0, 1));
      tick(); guard++;
    end
    bus.wr_en = 1'b1; bus.mem_ready = 1'b1;
    tick();
    chk("bp_timeout", guard < 200, 1'b1);
    chk("bp_accepts", n_wr - wr0, FW);
    chk("bp_full_pulses", n_full, 2);

    // read frames: nominal latency, then long latency to hit the read cap
    read_frame(5);
    out_max = 0;
    read_frame(12);
    chk("max_outstanding_reached", out_max, MAXO);
    chk("rd_done_pulses", n_done, 2);

    // simultaneous requests: writes win
    wr0 = n_wr; rd0 = n_rd; lat = 5;
    bus.rd_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.wr_en = 1'b0; bus.wr_data = DW'($urandom);
      tick();
    end
    chk("sim_writes", n_wr - wr0, 4);
    chk("sim_reads", n_rd - rd0, 0);
    bus.wr_en = 1'b1; bus.rd_en = 1'b0;
    tick();
    chk("sim_rd_addr_zero", last_addr, AW'(BASE));
    bus.wr_en = 1'b0; bus.rd_en = 1'b1; bus.wr_data = DW'($urandom);
    tick();
    chk("sim_wr_addr_four", last_addr, AW'(BASE + 4));
    bus.wr_en = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    // spurious return with nothing outstanding
    spur = 1; tick(); spur = 0;
    chk("spur_no_valid", bus.rd_data_valid, 1'b0);
    chk("spur_perr_set", bus.protocol_err, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    chk("spur_perr_sticky", bus.protocol_err, 1'b1);

    // reset in the middle of a frame read
    reset = 1'b0; #1;
    model_reset();
    reset = 1'b1;
    rd0 = n_rd; guard = 0;
    bus.rd_en = 1'b0;
    while (n_rd - rd0 < 10 && guard < 100) begin tick(); guard++; end
    chk("mr_issue_timeout", guard < 100, 1'b1);
    reset = 1'b0; #1;
    chk("mr_rd_data_valid", bus.rd_data_valid, 1'b0);
    chk("mr_rd_data", bus.rd_data, '0);
    chk("mr_full", bus.full, 1'b0);
    chk("mr_rd_done", bus.rd_done, 1'b0);
    chk("mr_protocol_err", bus.protocol_err, 1'b0);
    chk("mr_mem_read_req", bus.mem_read_req, 1'b0);
    chk("mr_mem_write_req", bus.mem_write_req, 1'b0);
    model_reset();
    reset = 1'b1;
    tick();
    chk("mr_first_addr_base", last_addr, AW'(BASE));
    bus.rd_en = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("mr_inflight_perr", bus.protocol_err, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fb_avl_port.md
Name: fb_avl_port

Overview:
- Frame-buffer port: the memory-side responder to the top-level capture controller's active-low wr_en/rd_en requests.
- Converts each accepted request into a single-word Avalon-MM write or read at an auto-incrementing frame address.
- Returns read data with a valid strobe; pulses full when a frame has been written and rd_done when a frame has been read back.
- One instance per frame buffer (buffers 0 and 1), sitting between the controller and the DDR memory controller.

Parameters:
- DATA_WIDTH, 32: width of the pixel word on both sides.
- ADDR_WIDTH, 26: Avalon word-address width.
- BASE_ADDR, 0: word address of pixel 0 of this buffer.
- FRAME_WORDS, 307200: words per frame (640x480).
- MAX_OUTSTANDING, 8: maximum issued-but-unreturned reads; range 1..15.

Ports:
- clk  in  1  fast memory-domain clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  active-low write request from the controller.
- wr_data  in  DATA_WIDTH  write pixel word.
- rd_en  in  1  active-low read request from the controller.
- avl_ready  out  1  port can accept a write this cycle.
- rd_data  out  DATA_WIDTH  read pixel word (registered).
- rd_data_valid  out  1  rd_data valid this cycle.
- full  out  1  one-cycle pulse: last word of a frame written.
- rd_done  out  1  one-cycle pulse: last word of a frame returned.
- protocol_err  out  1  sticky: read data returned with no outstanding read.
- mem_address  out  ADDR_WIDTH  Avalon address.
- mem_write_req  out  1  Avalon write request.
- mem_read_req  out  1  Avalon read request.
- mem_wdata  out  DATA_WIDTH  Avalon write data.
- mem_ready  in  1  memory accepts a request this cycle (inverse waitrequest).
- mem_rdata  in  DATA_WIDTH  Avalon read data.
- mem_rdata_valid  in  1  Avalon read data valid.

Behaviour:
- **Reset** (asynchronous, while reset is low):
  - wr_addr, rd_addr, issued count and outstanding count go to 0.
  - State goes to S_RUN.
  - All outputs go to 0: rd_data, rd_data_valid, full, rd_done, protocol_err, mem_* requests.
- **Request path**: mem_* request outputs are combinational from the request inputs and current state.
- **avl_ready** = mem_ready.
- **Write accept**:
  - Condition: wr_en==0 && mem_ready==1.
  - mem_write_req=1, mem_address=BASE_ADDR+wr_addr, mem_wdata=wr_data.
  - wr_addr increments on the edge.
  - If wr_addr==FRAME_WORDS-1: wr_addr wraps to 0 and full pulses high for the next cycle only.
- **Read issue**:
  - Condition: rd_en==0 && wr_en==1 && mem_ready==1 && state==S_RUN && outstanding<MAX_OUTSTANDING.
  - mem_read_req=1, mem_address=BASE_ADDR+rd_addr; rd_addr and issued increment.
  - When issued reaches FRAME_WORDS: state goes to S_DRAIN and rd_addr wraps to 0.
- **Priority**: writes beat reads. If wr_en and rd_en are both low, only the write is issued; the read is silently not issued that cycle. The controller retries by holding rd_en.
- **Outstanding counter**:
  - +1 on read issue, -1 on mem_rdata_valid; both in the same cycle leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING.
- **Read return**:
  - mem_rdata_valid with outstanding>0: rd_data<=mem_rdata, rd_data_valid<=1 on the next edge (1-cycle latency).
  - mem_rdata_valid with outstanding==0: data dropped, rd_data_valid stays 0, protocol_err set to 1 until reset.
- **State S_DRAIN**:
  - No reads issued; writes unaffected.
  - When the final return arrives (outstanding goes 1->0): rd_done pulses in the same cycle as its rd_data_valid, issued clears to 0, state goes to S_RUN.
- **Address arithmetic**: counters use clog2(FRAME_WORDS) bits; the address sum is truncated to ADDR_WIDTH.
- **Idle/unused**: no request when wr_en and rd_en are both high. mem_address holds BASE_ADDR+rd_addr when idle.
- **Reset mid-frame**: counters restart at word 0. In-flight returns after reset are dropped and flag protocol_err.

Test Plan:
- **Write frame**: FRAME_WORDS=16, mem_ready=1, wr_en low 16 cycles with data 0..15 -> addresses BASE..BASE+15; full high exactly one cycle after the 16th accept; wr_addr back to 0.
- **Backpressure**: mem_ready toggled 1,0,1,0 during writes -> accepts only on mem_ready=1 cycles; addresses stay contiguous, no skipped or duplicate words.
- **Read frame**: memory model with 5-cycle latency, rd_en held low -> at most 8 reads outstanding; 16 rd_data_valid pulses with data 0..15 in order; rd_done coincides with the 16th valid; no read issued in S_DRAIN.
- **Simultaneous requests**: wr_en=0 and rd_en=0 for 4 cycles -> 4 writes, 0 reads, wr_addr=4, rd_addr=0.
- **Spurious return**: mem_rdata_valid=1 with no reads issued -> rd_data_valid stays 0, protocol_err=1 and stays 1 until reset.
- **Reset mid-read**: assert reset after 10 reads issued -> all outputs 0 immediately (asynchronous); after release, next read address is BASE_ADDR.
